// File: rtl/seq_divider_if.sv
// seq_divider_if: request/response handshake bundle for seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             i_signed;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             zero_flag;
    logic             exception_flag;
    logic             overflow_flag;

    modport master (
        output i_valid, i_dividend, i_divisor, i_signed, i_ready,
        input  o_ready, o_valid, o_quotient, o_remainder, zero_flag, exception_flag, overflow_flag
    );

    modport slave (
        input  i_valid, i_dividend, i_divisor, i_signed, i_ready,
        output o_ready, o_valid, o_quotient, o_remainder, zero_flag, exception_flag, overflow_flag
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-and-subtract divider, one quotient bit per clock.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs_mag, dvd_raw;
    logic             sgn, dvd_neg, dvs_neg, div0, ovf;
    logic [WIDTH-1:0] q_r, r_r;
    logic             zf_r, ef_r, of_r;
    logic             accept, last, ge;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign accept = bus.i_valid && (state == IDLE);
    assign last   = (cnt == CW'(1));
    assign rem_s  = {rem, quo[WIDTH-1]};
    assign ge     = (rem_s >= {1'b0, dvs_mag});
    assign rem_n  = ge ? WIDTH'(rem_s - {1'b0, dvs_mag}) : rem_s[WIDTH-1:0];
    assign quo_n  = {quo[WIDTH-2:0], ge};
    // Truncating division: quotient sign from operand signs, remainder follows the dividend
    assign q_fix  = (sgn && (dvd_neg ^ dvs_neg)) ? -quo_n : quo_n;
    assign r_fix  = (sgn && dvd_neg) ? -rem_n : rem_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // Special cases pass through one CALC cycle so their latency is a single cycle
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = bus.i_valid ? CALC : IDLE;
            CALC:    state_n = (div0 || ovf || last) ? DONE : CALC;
            DONE:    state_n = bus.i_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs_mag <= '0;
            dvd_raw <= '0;
            sgn     <= 1'b0;
            dvd_neg <= 1'b0;
            dvs_neg <= 1'b0;
            div0    <= 1'b0;
            ovf     <= 1'b0;
            q_r     <= '0;
            r_r     <= '0;
            zf_r    <= 1'b0;
            ef_r    <= 1'b0;
            of_r    <= 1'b0;
        end else if (accept) begin
            sgn     <= bus.i_signed;
            dvd_neg <= bus.i_signed && bus.i_dividend[WIDTH-1];
            dvs_neg <= bus.i_signed && bus.i_divisor[WIDTH-1];
            dvd_raw <= bus.i_dividend;
            div0    <= (bus.i_divisor == '0);
            ovf     <= bus.i_signed && (bus.i_dividend == MIN) && (&bus.i_divisor);
            cnt     <= CW'(WIDTH);
            rem     <= '0;
            quo     <= mag(bus.i_dividend, bus.i_signed);
            dvs_mag <= mag(bus.i_divisor, bus.i_signed);
        end else if (state == CALC) begin
            if (div0) begin
                q_r  <= '1;
                r_r  <= dvd_raw;
                zf_r <= 1'b0;
                ef_r <= 1'b1;
                of_r <= 1'b0;
            end else if (ovf) begin
                q_r  <= MIN;
                r_r  <= '0;
                zf_r <= 1'b0;
                ef_r <= 1'b0;
                of_r <= 1'b1;
            end else begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt - CW'(1);
                if (last) begin
                    q_r  <= q_fix;
                    r_r  <= r_fix;
                    zf_r <= (q_fix == '0);
                    ef_r <= 1'b0;
                    of_r <= 1'b0;
                end
            end
        end
    end

    assign bus.o_ready        = (state == IDLE);
    assign bus.o_valid        = (state == DONE);
    assign bus.o_quotient     = q_r;
    assign bus.o_remainder    = r_r;
    assign bus.zero_flag      = zf_r;
    assign bus.exception_flag = ef_r;
    assign bus.overflow_flag  = of_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with a scoreboard queue and a decoupled result monitor.
module tb_seq_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic        e;
        logic        o;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc = 0;
    logic have = 1'b0;
    logic xfer = 1'b0;
    exp_t cur;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(32)) bus();
    seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (xfer) begin
                chk("post_xfer_valid", 64'(bus.o_valid), 64'(0));
                chk("post_xfer_ready", 64'(bus.o_ready), 64'(1));
                xfer = 1'b0;
            end
            if (bus.i_valid && bus.o_ready) acc = cyc;
            if (bus.o_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result q=%0h", bus.o_quotient);
                    end else begin
                        cur = sb.pop_front();
                        have = 1'b1;
                        chk("latency", 64'(cyc - 1 - acc), 64'(cur.lat));
                    end
                end
                if (have) begin
                    chk("quotient", 64'(bus.o_quotient), 64'(cur.q));
                    chk("remainder", 64'(bus.o_remainder), 64'(cur.r));
                    chk("zero_flag", 64'(bus.zero_flag), 64'(cur.z));
                    chk("exception_flag", 64'(bus.exception_flag), 64'(cur.e));
                    chk("overflow_flag", 64'(bus.overflow_flag), 64'(cur.o));
                    chk("ready_in_done", 64'(bus.o_ready), 64'(0));
                end
                if (bus.i_ready) begin
                    have = 1'b0;
                    xfer = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs, input logic s,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input logic ee, input logic eo, input int el, input int hold);
        int n;
        exp_t x;
        n = 0;
        while (!bus.o_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_ready) begin
            checks++;
            failures++;
            $display("FAIL timeout_ready actual=0 expected=1");
        end
        bus.i_dividend = dvd;
        bus.i_divisor  = dvs;
        bus.i_signed   = s;
        bus.i_valid    = 1'b1;
        bus.i_ready    = (hold == 0);
        x = '{eq, er, ez, ee, eo, el};
        sb.push_back(x);
        @(posedge clk); #1;
        bus.i_valid    = 1'b0;
        bus.i_dividend = $urandom;
        bus.i_divisor  = $urandom;
        bus.i_signed   = ~s;
    endtask

    task automatic do_div(input logic [31:0] dvd, input logic [31:0] dvs, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input logic ee, input logic eo, input int el, input int hold);
        int n;
        issue(dvd, dvs, s, eq, er, ez, ee, eo, el, hold);
        n = 0;
        while (!bus.o_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout_valid actual=0 expected=1");
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            bus.i_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b1;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;
        bus.i_signed   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_ready", 64'(bus.o_ready), 64'(1));
        chk("rst_quotient", 64'(bus.o_quotient), 64'(0));
        chk("rst_remainder", 64'(bus.o_remainder), 64'(0));
        chk("rst_flags", 64'({bus.zero_flag, bus.exception_flag, bus.overflow_flag}), 64'(0));
        rst_n = 1'b1;

        do_div(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 1'b0, 32, 0);
        do_div(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 32, 0);
        do_div(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 1'b0, 32, 0);
        do_div(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 32, 0);
        do_div(32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 32, 0);
        do_div(32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b0, 1'b1, 1'b0, 1,  0);
        do_div(32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b0, 1'b1, 1'b0, 1,  0);
        do_div(32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b0, 1'b1, 1'b0, 1,  0);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b0, 1'b1, 1,  0);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b1, 1'b0, 1'b0, 32, 0);
        do_div(32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,          1'b0, 1'b0, 1'b0, 32, 5);

        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0, 32, 0);
        repeat (16) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", 64'(bus.o_valid), 64'(0));
        chk("midrst_ready", 64'(bus.o_ready), 64'(1));
        chk("midrst_quotient", 64'(bus.o_quotient), 64'(0));
        chk("midrst_remainder", 64'(bus.o_remainder), 64'(0));
        chk("midrst_flags", 64'({bus.zero_flag, bus.exception_flag, bus.overflow_flag}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_div(32'd3, 32'd3, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 32, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
